// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// core writeback path (port A) and the GPIO capture/debug path (port B).
// Each port feeds a 2-entry FIFO. A round-robin drain moves at most one entry
// per cycle into a registered write command. rd_hazard flags reads of
// registers that still have a write queued or in flight.
//
// Handshake (ports A and B): a request transfers on a rising edge where
// x_valid && x_ready. x_ready depends only on FIFO occupancy, never on x_valid.
// Once the requester raises x_valid, it holds x_valid and its payload stable
// until the transfer happens.
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_d_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_hazard,
    output logic                  busy,
    output logic                  arb_state    // debug: 0 = A_FIRST, 1 = B_FIRST
);

    typedef enum logic {
        A_FIRST = 1'b0,
        B_FIRST = 1'b1
    } rr_state_t;

    rr_state_t rr_next;

    // FIFO A storage and pointers
    logic [ADDR_WIDTH-1:0] a_addr_q [2];
    logic [DATA_WIDTH-1:0] a_data_q [2];
    logic                  a_wr_ptr;
    logic                  a_rd_ptr;
    logic [1:0]            a_count;

    // FIFO B storage and pointers
    logic [ADDR_WIDTH-1:0] b_addr_q [2];
    logic [DATA_WIDTH-1:0] b_data_q [2];
    logic                  b_wr_ptr;
    logic                  b_rd_ptr;
    logic [1:0]            b_count;

    logic                  push_a;
    logic                  push_b;
    logic                  a_ne;
    logic                  b_ne;
    logic                  pop_a;
    logic                  pop_b;
    logic                  popped;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic [DATA_WIDTH-1:0] pop_data;

    logic                  a_vld0;
    logic                  a_vld1;
    logic                  b_vld0;
    logic                  b_vld1;
    logic                  hz_a;
    logic                  hz_b;

    // Ready is purely occupancy based: a full FIFO refuses even while it pops.
    assign a_ready = (a_count != 2'd2);
    assign b_ready = (b_count != 2'd2);
    assign push_a  = a_valid && a_ready;
    assign push_b  = b_valid && b_ready;

    // Drain selection: a lone non-empty FIFO wins, otherwise rr_next decides.
    assign a_ne     = (a_count != 2'd0);
    assign b_ne     = (b_count != 2'd0);
    assign pop_a    = a_ne && (!b_ne || (rr_next == A_FIRST));
    assign pop_b    = b_ne && !pop_a;
    assign popped   = pop_a || pop_b;
    assign pop_addr = pop_a ? a_addr_q[a_rd_ptr] : b_addr_q[b_rd_ptr];
    assign pop_data = pop_a ? a_data_q[a_rd_ptr] : b_data_q[b_rd_ptr];

    // Which storage slots hold live entries (count 1 means only the head).
    assign a_vld0 = (a_count == 2'd2) || ((a_count == 2'd1) && !a_rd_ptr);
    assign a_vld1 = (a_count == 2'd2) || ((a_count == 2'd1) &&  a_rd_ptr);
    assign b_vld0 = (b_count == 2'd2) || ((b_count == 2'd1) && !b_rd_ptr);
    assign b_vld1 = (b_count == 2'd2) || ((b_count == 2'd1) &&  b_rd_ptr);

    // Register 0 is never written, so a read of it can never be hazardous.
    assign hz_a = (rd_addr_a != '0) &&
                  ((a_vld0 && (a_addr_q[0] == rd_addr_a)) ||
                   (a_vld1 && (a_addr_q[1] == rd_addr_a)) ||
                   (b_vld0 && (b_addr_q[0] == rd_addr_a)) ||
                   (b_vld1 && (b_addr_q[1] == rd_addr_a)) ||
                   (rf_we  && (rf_w_addr   == rd_addr_a)));
    assign hz_b = (rd_addr_b != '0) &&
                  ((a_vld0 && (a_addr_q[0] == rd_addr_b)) ||
                   (a_vld1 && (a_addr_q[1] == rd_addr_b)) ||
                   (b_vld0 && (b_addr_q[0] == rd_addr_b)) ||
                   (b_vld1 && (b_addr_q[1] == rd_addr_b)) ||
                   (rf_we  && (rf_w_addr   == rd_addr_b)));
    assign rd_hazard = hz_a || hz_b;

    assign busy      = a_ne || b_ne || rf_we;
    assign arb_state = (rr_next == B_FIRST);

    // FIFO A: write at wr_ptr, read at rd_ptr, count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_addr_q[0] <= '0;
            a_addr_q[1] <= '0;
            a_data_q[0] <= '0;
            a_data_q[1] <= '0;
            a_wr_ptr    <= 1'b0;
            a_rd_ptr    <= 1'b0;
            a_count     <= 2'd0;
        end else begin
            if (push_a) begin
                a_addr_q[a_wr_ptr] <= a_addr;
                a_data_q[a_wr_ptr] <= a_data;
                a_wr_ptr           <= ~a_wr_ptr;
            end
            if (pop_a) begin
                a_rd_ptr <= ~a_rd_ptr;
            end
            case ({push_a, pop_a})
                2'b10:   a_count <= a_count + 2'd1;
                2'b01:   a_count <= a_count - 2'd1;
                default: a_count <= a_count;
            endcase
        end
    end

    // FIFO B: same structure as FIFO A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_addr_q[0] <= '0;
            b_addr_q[1] <= '0;
            b_data_q[0] <= '0;
            b_data_q[1] <= '0;
            b_wr_ptr    <= 1'b0;
            b_rd_ptr    <= 1'b0;
            b_count     <= 2'd0;
        end else begin
            if (push_b) begin
                b_addr_q[b_wr_ptr] <= b_addr;
                b_data_q[b_wr_ptr] <= b_data;
                b_wr_ptr           <= ~b_wr_ptr;
            end
            if (pop_b) begin
                b_rd_ptr <= ~b_rd_ptr;
            end
            case ({push_b, pop_b})
                2'b10:   b_count <= b_count + 2'd1;
                2'b01:   b_count <= b_count - 2'd1;
                default: b_count <= b_count;
            endcase
        end
    end

    // Round-robin state plus the registered write command. An address-0 pop
    // consumes its grant slot but never raises rf_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_next   <= A_FIRST;
            rf_we     <= 1'b0;
            rf_w_addr <= '0;
            rf_d_in   <= '0;
        end else begin
            if (pop_a) begin
                rr_next <= B_FIRST;
            end else if (pop_b) begin
                rr_next <= A_FIRST;
            end
            rf_we <= popped && (pop_addr != '0);
            if (popped) begin
                rf_w_addr <= pop_addr;
                rf_d_in   <= pop_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios followed by a random
// stream, checked against a queue-based reference model of the two ports.
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int EW = AW + DW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          a_ready;
    logic          b_valid = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          b_ready;
    logic          rf_we;
    logic [AW-1:0] rf_w_addr;
    logic [DW-1:0] rf_d_in;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          rd_hazard;
    logic          busy;
    logic          arb_state;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_we     (rf_we),
        .rf_w_addr (rf_w_addr),
        .rf_d_in   (rf_d_in),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_hazard (rd_hazard),
        .busy      (busy),
        .arb_state (arb_state)
    );

    int total = 0;
    int bad   = 0;

    // reference model: per-port request queues and the expected write command
    logic [EW-1:0] qa[$];
    logic [EW-1:0] qb[$];
    logic [EW-1:0] exp_q[$];
    logic          m_rr   = 1'b0;   // 0: A wins a tie, 1: B wins a tie
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] dut_rf [32];
    logic [DW-1:0] exp_rf [32];

    logic acc_a;
    logic acc_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_pending(input logic [AW-1:0] r);
        if (r == '0) return 1'b0;
        foreach (qa[i]) if (qa[i][EW-1:DW] == r) return 1'b1;
        foreach (qb[i]) if (qb[i][EW-1:DW] == r) return 1'b1;
        if (m_we && (m_addr == r)) return 1'b1;
        return 1'b0;
    endfunction

    // driver: one clock cycle of stimulus, with model update and checks
    task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         output logic got_a, output logic got_b);
        logic [EW-1:0] head;
        logic          popped;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        chk("a_ready", 64'(a_ready), 64'(qa.size() < 2));
        chk("b_ready", 64'(b_ready), 64'(qb.size() < 2));
        chk("rd_hazard", 64'(rd_hazard), 64'(addr_pending(rd_addr_a) || addr_pending(rd_addr_b)));
        got_a  = av && (qa.size() < 2);
        got_b  = bv && (qb.size() < 2);
        popped = 1'b0;
        head   = '0;
        m_we   = 1'b0;
        if (qa.size() > 0 && (qb.size() == 0 || m_rr == 1'b0)) begin
            head = qa.pop_front(); m_rr = 1'b1; popped = 1'b1;
        end else if (qb.size() > 0) begin
            head = qb.pop_front(); m_rr = 1'b0; popped = 1'b1;
        end
        if (popped) begin
            m_addr = head[EW-1:DW];
            m_data = head[DW-1:0];
            m_we   = (m_addr != '0);
            if (m_we) begin
                exp_q.push_back(head);
                exp_rf[m_addr] = m_data;
            end
        end
        if (got_a) qa.push_back({aa, ad});
        if (got_b) qb.push_back({ba, bd});
        @(posedge clk);
        #1;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_w_addr", 64'(rf_w_addr), 64'(m_addr));
        chk("rf_d_in", 64'(rf_d_in), 64'(m_data));
        chk("busy", 64'(busy), 64'(qa.size() > 0 || qb.size() > 0 || m_we));
        chk("arb_state", 64'(arb_state), 64'(m_rr));
        if (rf_we === 1'b1) begin
            dut_rf[rf_w_addr] = rf_d_in;
            if (exp_q.size() == 0) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL commit_extra observed=%0h expected=none", {rf_w_addr, rf_d_in});
                end
            end else begin
                chk("commit", 64'({rf_w_addr, rf_d_in}), 64'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, acc_a, acc_b);
    endtask

    // asynchronous reset pulse, asserted away from the clock edge
    task automatic reset_dut();
        a_valid = 1'b0; b_valid = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'(0));
        chk("rst_rf_w_addr", 64'(rf_w_addr), 64'(0));
        chk("rst_rf_d_in", 64'(rf_d_in), 64'(0));
        chk("rst_a_ready", 64'(a_ready), 64'(1));
        chk("rst_b_ready", 64'(b_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_arb_state", 64'(arb_state), 64'(0));
        chk("rst_hazard", 64'(rd_hazard), 64'(0));
        qa.delete(); qb.delete(); exp_q.delete();
        m_rr = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
        @(posedge clk);
        #1;
        chk("rst_hold_we", 64'(rf_we), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        int sa;
        int sb;
        int low_a;
        int low_b;
        int n;
        logic          pa_v;
        logic [AW-1:0] pa_addr;
        logic [DW-1:0] pa_data;
        logic          pb_v;
        logic [AW-1:0] pb_addr;
        logic [DW-1:0] pb_data;

        for (int i = 0; i < 32; i++) begin
            dut_rf[i] = '0;
            exp_rf[i] = '0;
        end

        // single write, no contention
        reset_dut();
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, acc_a, acc_b);
        chk("t1_accept", 64'(acc_a), 64'(1));
        idle(1);
        chk("t1_we", 64'(rf_we), 64'(1));
        chk("t1_addr", 64'(rf_w_addr), 64'(5));
        chk("t1_data", 64'(rf_d_in), 64'(32'hDEADBEEF));
        idle(1);
        chk("t1_busy_done", 64'(busy), 64'(0));

        // simultaneous same-address writes: A first, B one cycle later
        reset_dut();
        cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, acc_a, acc_b);
        idle(1);
        chk("t2_first", 64'({rf_we, rf_d_in}), 64'({1'b1, 32'h11}));
        idle(1);
        chk("t2_second", 64'({rf_we, rf_d_in}), 64'({1'b1, 32'h22}));
        idle(2);
        chk("t2_reg3", 64'(dut_rf[3]), 64'(32'h22));

        // both ports streaming 8 writes each
        reset_dut();
        sa = 0; sb = 0; low_a = 0; low_b = 0;
        for (int c = 0; c < 60 && (sa < 8 || sb < 8); c++) begin
            cycle(sa < 8, AW'(8 + sa), DW'(32'hA00 + sa), sb < 8, AW'(16 + sb), DW'(32'hB00 + sb),
                  acc_a, acc_b);
            if (acc_a) sa++;
            if (acc_b) sb++;
            if (a_ready === 1'b0) low_a++;
            if (b_ready === 1'b0) low_b++;
        end
        idle(4);
        chk("t3_sent_a", 64'(sa), 64'(8));
        chk("t3_sent_b", 64'(sb), 64'(8));
        chk("t3_a_stalled", 64'(low_a > 0), 64'(1));
        chk("t3_b_stalled", 64'(low_b > 0), 64'(1));
        chk("t3_last_a", 64'(dut_rf[15]), 64'(32'hA07));
        chk("t3_last_b", 64'(dut_rf[23]), 64'(32'hB07));

        // backpressure on A while B streams; A holds each request until taken
        reset_dut();
        sa = 0; sb = 0; low_a = 0;
        for (int c = 0; c < 40 && sa < 3; c++) begin
            cycle(1'b1, (sa == 0) ? 5'd1 : (sa == 1) ? 5'd2 : 5'd4, DW'(32'hC0 + sa),
                  1'b1, AW'(10 + (sb % 4)), DW'(32'hD0 + sb), acc_a, acc_b);
            if (acc_a) sa++;
            if (acc_b) sb++;
            if (a_ready === 1'b0) low_a++;
        end
        idle(6);
        chk("t4_a_stalled", 64'(low_a > 0), 64'(1));
        chk("t4_a_third", 64'(dut_rf[4]), 64'(32'hC2));
        chk("t4_a_first", 64'(dut_rf[1]), 64'(32'hC0));

        // address 0 never writes
        reset_dut();
        cycle(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, acc_a, acc_b);
        idle(1);
        chk("t5_no_we", 64'(rf_we), 64'(0));
        chk("t5_reg0", 64'(dut_rf[0]), 64'(0));

        // hazard window for a write to register 7
        rd_addr_a = 5'd7;
        cycle(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, acc_a, acc_b);
        chk("t5_hz_queued", 64'(rd_hazard), 64'(1));
        idle(1);
        chk("t5_hz_inflight", 64'({rf_we, rd_hazard}), 64'(2'b11));
        idle(1);
        chk("t5_hz_clear", 64'(rd_hazard), 64'(0));
        rd_addr_a = '0;

        // reads of register 0 never flag a hazard
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 5'd0 : AW'(i), DW'(i), 1'b1, '0, DW'(i + 100), acc_a, acc_b);
            chk("t5_hz_zero", 64'(rd_hazard), 64'(0));
        end
        idle(4);

        // reset in the middle of a busy stream
        sa = 0; n = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, AW'(20 + (c % 4)), DW'(32'hE0 + c), 1'b1, AW'(24 + (c % 4)), DW'(32'hF0 + c),
                  acc_a, acc_b);
            if (qa.size() + qb.size() == 3 && m_we) begin
                n = 1;
                break;
            end
        end
        chk("t6_loaded", 64'(n), 64'(1));
        reset_dut();
        idle(3);
        chk("t6_quiet", 64'({rf_we, busy}), 64'(0));

        // random traffic with strict valid/ready on both ports
        reset_dut();
        pa_v = 1'b0; pb_v = 1'b0;
        pa_addr = '0; pa_data = '0; pb_addr = '0; pb_data = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa_v && $urandom_range(0, 99) < 60) begin
                pa_v = 1'b1;
                pa_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
                pa_data = $urandom;
            end
            if (!pb_v && $urandom_range(0, 99) < 45) begin
                pb_v = 1'b1;
                pb_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
                pb_data = $urandom;
            end
            rd_addr_a = ($urandom_range(0, 1) == 0) ? pa_addr : AW'($urandom_range(0, 31));
            rd_addr_b = ($urandom_range(0, 1) == 0) ? pb_addr : AW'($urandom_range(0, 31));
            cycle(pa_v, pa_addr, pa_data, pb_v, pb_addr, pb_data, acc_a, acc_b);
            if (acc_a) pa_v = 1'b0;
            if (acc_b) pb_v = 1'b0;
        end
        rd_addr_a = '0; rd_addr_b = '0;
        idle(6);
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < 32; i++) chk("rand_regfile", 64'(dut_rf[i]), 64'(exp_rf[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
